// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU byte/halfword/word access into a single
// word-aligned memory request with lane enables, an ack timeout and load extension.
//
// state | meaning
// IDLE  | waiting for req_valid; the request is registered on acceptance
// ISSUE | mem_req held high until mem_ack or until the timeout expires
// RESP  | one-cycle done pulse carrying err/rdata, then back to IDLE
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, sgn_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        req_legal;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  always_comb begin
    case (req_size)
      2'b00:   req_legal = 1'b1;
      2'b01:   req_legal = ~req_addr[0];
      2'b10:   req_legal = (req_addr[1:0] == 2'b00);
      default: req_legal = 1'b0;
    endcase
  end

  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0;
    case (size_q)
      2'b00: begin
        be        = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be        = 4'b1111;
        wdata_rep = wdata_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{sgn_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = {{16{sgn_q & half_lane[15]}}, half_lane};
      default: load_ext = mem_rdata;
    endcase
  end

  // Ack is tested before the terminal count, so an ack in the last allowed cycle still succeeds.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = req_legal ? S_ISSUE : S_RESP;
          cnt_d   = TO_LOAD;
        end
      end
      S_ISSUE: begin
        if (mem_ack || cnt_q == 8'd0) state_d = S_RESP;
        else                          cnt_d   = cnt_q - 8'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req_valid) begin
        we_q    <= req_write;
        sgn_q   <= req_signed;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= ~req_legal;
        rdata_q <= 32'h0;
      end else if (state_q == S_ISSUE) begin
        if (mem_ack) begin
          err_q   <= 1'b0;
          rdata_q <= we_q ? 32'h0 : load_ext;
        end else if (cnt_q == 8'd0) begin
          err_q   <= 1'b1;
          rdata_q <= 32'h0;
        end
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_RESP);
  assign err       = done & err_q;
  assign rdata     = rdata_q;
  assign mem_req   = (state_q == S_ISSUE);
  assign mem_we    = mem_req & we_q;
  assign mem_be    = mem_req ? be : 4'b0000;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_rep;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written reset and
// back-to-back sequences, and randomized accesses against an arithmetic reference model.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mrd;
    int          ack_at;   // ISSUE cycle (1-based) in which mem_ack is given; 0 = never
    logic        e_err;
    logic [31:0] e_rdata;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    int          e_lat;    // cycles counting the request cycle as cycle 1
    int          e_issue;
  } vec_t;

  // Reference model: lane arithmetic straight from the access rules.
  task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] mrd,
                       input int ack_at, output logic e_err, output logic [31:0] e_rdata,
                       output logic [3:0] e_be, output logic [31:0] e_wd,
                       output int e_lat, output int e_issue);
    int off;
    bit bad;
    logic [31:0] v;
    off = int'(ad % 4);
    bad = (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0);
    e_be = 4'd0;
    e_wd = 32'h0;
    if (sz == 2'd0) begin
      e_be = 4'(1 << off);
      e_wd = (wd % 256) * 32'h01010101;
    end else if (sz == 2'd1) begin
      e_be = 4'(3 << off);
      e_wd = (wd % 65536) * 32'h00010001;
    end else if (sz == 2'd2) begin
      e_be = 4'd15;
      e_wd = wd;
    end
    if (bad) begin
      e_err = 1'b1; e_rdata = 32'h0; e_lat = 2; e_issue = 0;
    end else if (ack_at >= 1 && ack_at <= TO) begin
      e_err = 1'b0; e_lat = ack_at + 2; e_issue = ack_at;
      v = mrd >> (8 * off);
      if (we)              e_rdata = 32'h0;
      else if (sz == 2'd0) begin
        v = v % 256;
        e_rdata = (sg && v >= 128) ? v + 32'hFFFFFF00 : v;
      end else if (sz == 2'd1) begin
        v = v % 65536;
        e_rdata = (sg && v >= 32768) ? v + 32'hFFFF0000 : v;
      end else e_rdata = mrd;
    end else begin
      e_err = 1'b1; e_rdata = 32'h0; e_lat = TO + 2; e_issue = TO;
    end
  endtask

  task automatic run_access(input string tag, input vec_t v);
    int issue_cnt, lat;
    logic stable, idle_ok, got_err;
    logic [31:0] got_rdata, e_addr;
    e_addr = {v.addr[31:2], 2'b00};
    @(negedge clk);
    req_valid = 1'b1; req_write = v.we; req_size = v.sz; req_signed = v.sg;
    req_addr = v.addr; req_wdata = v.wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    issue_cnt = 0; lat = -1; stable = 1'b1; idle_ok = 1'b1;
    got_err = 1'b0; got_rdata = 32'h0;
    for (int n = 1; n <= 40; n++) begin
      if (mem_req) begin
        issue_cnt++;
        if (issue_cnt == 1) begin
          chk({tag, " mem_addr"}, mem_addr, e_addr);
          chk({tag, " mem_be"}, {28'h0, mem_be}, {28'h0, v.e_be});
          chk({tag, " mem_we"}, {31'h0, mem_we}, {31'h0, v.we});
          chk({tag, " mem_wdata"}, mem_wdata, v.e_wd);
        end else if (mem_addr !== e_addr || mem_be !== v.e_be || mem_we !== v.we ||
                     mem_wdata !== v.e_wd) stable = 1'b0;
        mem_ack   = (issue_cnt == v.ack_at);
        mem_rdata = v.mrd;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_we !== 1'b0 || mem_be !== 4'd0) idle_ok = 1'b0;
      end
      if (done) begin
        lat = n + 1;
        got_err = err;
        got_rdata = rdata;
        chk({tag, " busy_in_done"}, {31'h0, busy}, 32'd1);
        break;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk({tag, " latency"}, lat, v.e_lat);
    chk({tag, " err"}, {31'h0, got_err}, {31'h0, v.e_err});
    chk({tag, " rdata"}, got_rdata, v.e_rdata);
    chk({tag, " issue_cycles"}, issue_cnt, v.e_issue);
    chk({tag, " held_stable"}, {31'h0, stable}, 32'd1);
    chk({tag, " idle_outputs_zero"}, {31'h0, idle_ok}, 32'd1);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, {31'h0, done}, 32'd0);
    chk({tag, " busy_after"}, {31'h0, busy}, 32'd0);
  endtask

  vec_t tbl[11];
  logic mr[20], dn[20], bz[20];

  initial begin
    // we sz sg addr wdata mrdata ack_at | err rdata be wdata lat issue
    tbl[0]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h12345678, 32'h80FFFFFF, 1,  1'b0, 32'hFFFFFF80, 4'b1000, 32'h78787878, 3, 1};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 32'h022, 32'h0000BEEF, 32'h0,        1,  1'b0, 32'h0,        4'b1100, 32'hBEEFBEEF, 3, 1};
    tbl[2]  = '{1'b0, 2'd2, 1'b0, 32'h006, 32'h0,        32'h0,        1,  1'b1, 32'h0,        4'b1111, 32'h0,        2, 0};
    tbl[3]  = '{1'b0, 2'd1, 1'b0, 32'h040, 32'h0,        32'hFFFFFFFF, 0,  1'b1, 32'h0,        4'b0011, 32'h0,        18, 16};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h080, 32'h0,        32'hCAFEF00D, 16, 1'b0, 32'hCAFEF00D, 4'b1111, 32'h0,        18, 16};
    tbl[5]  = '{1'b0, 2'd3, 1'b0, 32'h000, 32'h0,        32'h0,        1,  1'b1, 32'h0,        4'b0000, 32'h0,        2, 0};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h041, 32'h0,        32'h0,        1,  1'b1, 32'h0,        4'b0110, 32'h0,        2, 0};
    tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h042, 32'h0,        32'h9ABC1234, 3,  1'b0, 32'hFFFF9ABC, 4'b1100, 32'h0,        5, 3};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 32'h001, 32'h0,        32'h0000F500, 2,  1'b0, 32'h000000F5, 4'b0010, 32'h0,        4, 2};
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h002, 32'hAABBCCDD, 32'hFFFFFFFF, 1,  1'b0, 32'h0,        4'b0100, 32'hDDDDDDDD, 3, 1};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h010, 32'h01020304, 32'h0,        1,  1'b0, 32'h0,        4'b1111, 32'h01020304, 3, 1};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'h0, busy}, 32'd0);
    chk("reset done", {31'h0, done}, 32'd0);
    chk("reset err", {31'h0, err}, 32'd0);
    chk("reset mem_req", {31'h0, mem_req}, 32'd0);
    chk("reset mem_we", {31'h0, mem_we}, 32'd0);
    chk("reset mem_be", {28'h0, mem_be}, 32'd0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_access($sformatf("vec%0d", i), tbl[i]);

    // Reset in the middle of ISSUE: request dropped, no done afterwards.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_issue mem_req_before", {31'h0, mem_req}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_issue mem_req", {31'h0, mem_req}, 32'd0);
    chk("rst_issue busy", {31'h0, busy}, 32'd0);
    chk("rst_issue mem_be", {28'h0, mem_be}, 32'd0);
    reset = 1'b0;
    begin
      int dcount = 0;
      for (int i = 0; i < 20; i++) begin
        if (done) dcount++;
        @(negedge clk);
      end
      chk("rst_issue no_done", dcount, 0);
    end
    begin
      vec_t v;
      v = '{1'b0, 2'd2, 1'b0, 32'h044, 32'h0, 32'h11223344, 1, 1'b0, 32'h11223344, 4'b1111, 32'h0, 3, 1};
      run_access("after_reset_lw", v);
    end

    // Back-to-back with req_valid held high and memory acking immediately.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h8;
    mem_rdata = 32'h5;
    for (int i = 0; i < 20; i++) begin
      if (i == 12) req_valid = 1'b0;
      mr[i] = mem_req; dn[i] = done; bz[i] = busy;
      mem_ack = mem_req;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    begin
      int d = -1;
      for (int i = 0; i < 16; i++) if (d < 0 && dn[i]) d = i;
      chk("b2b first_done_cycle", d, 2);
      if (d >= 0) begin
        chk("b2b gap_mem_req", {31'h0, mr[d+1]}, 32'd0);
        chk("b2b gap_busy", {31'h0, bz[d+1]}, 32'd0);
        chk("b2b next_mem_req", {31'h0, mr[d+2]}, 32'd1);
        chk("b2b next_done", {31'h0, dn[d+3]}, 32'd1);
      end
    end
    repeat (4) @(negedge clk);

    // Randomized accesses against the reference model.
    for (int i = 0; i < 150; i++) begin
      vec_t v;
      v.we = 1'($urandom_range(0, 1));
      v.sz = 2'($urandom_range(0, 3));
      v.sg = 1'($urandom_range(0, 1));
      v.addr = $urandom;
      v.wd = $urandom;
      v.mrd = $urandom;
      v.ack_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(1, 3));
      model(v.we, v.sz, v.sg, v.addr, v.wd, v.mrd, v.ack_at,
            v.e_err, v.e_rdata, v.e_be, v.e_wd, v.e_lat, v.e_issue);
      run_access($sformatf("rnd%0d", i), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
